// File: rtl/can_rx_hex_formatter_if.sv
// Byte-wise CAN receive stream in, ASCII character stream out.
// master = formatter side, slave = CAN controller / UART side.
interface can_rx_hex_formatter_if;
  logic        rx_valid;
  logic        rx_last;
  logic [7:0]  rx_data;
  logic [28:0] rx_id;
  logic        rx_ide;
  logic        o_tvalid;
  logic        o_tready;
  logic [7:0]  o_tdata;

  modport master (
    input  rx_valid, rx_last, rx_data, rx_id, rx_ide, o_tready,
    output o_tvalid, o_tdata
  );

  modport slave (
    output rx_valid, rx_last, rx_data, rx_id, rx_ide, o_tready,
    input  o_tvalid, o_tdata
  );
endinterface

// File: rtl/can_rx_hex_formatter.sv
// Buffers one received CAN frame and emits it as an uppercase hex ASCII line.
// Optional CAN_HEX_FMT_SPACE_EN inserts a space between consecutive data bytes.
module can_rx_hex_formatter #(
  parameter int MAX_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  can_rx_hex_formatter_if.master        bus,
  output logic [15:0]                   drop_cnt,
  output logic                          busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_PREFIX, S_ID, S_COLON, S_DATA,
`ifdef CAN_HEX_FMT_SPACE_EN
    S_SPACE,
`endif
    S_CR, S_LF
  } state_t;

  localparam logic [3:0] MAX_CNT  = 4'(MAX_BYTES);
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
`ifdef CAN_HEX_FMT_SPACE_EN
  localparam logic [7:0] CH_SP    = 8'h20;
`endif

  state_t      state_q, state_d;
  logic [3:0]  dig_q, dig_d, dig_nxt;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  id_last;
  logic [4:0]  data_last;
  logic [28:0] id_q;
  logic        ide_q;
  logic [7:0]  bytes_q [8];
  logic        tvalid_q, tvalid_d;
  logic [7:0]  tdata_q, tdata_d;
  logic [15:0] drop_q, drop_d;
  logic        store, latch_id, hs;
  logic [31:0] id_al;
  logic [7:0]  byte_nxt;
  logic [3:0]  id_nib0, id_nib_nxt, data_nib0, data_nib_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign hs        = tvalid_q & bus.o_tready;
  assign dig_nxt   = dig_q + 4'd1;
  assign id_last   = ide_q ? 4'd7 : 4'd2;
  assign data_last = {cnt_q, 1'b0} - 5'd1;

  // Left-align the ID so digit k is always the k-th nibble from the top.
  assign id_al        = ide_q ? {3'b000, id_q} : {1'b0, id_q[10:0], 20'h0};
  assign id_nib0      = id_al[31:28];
  assign id_nib_nxt   = 4'(id_al >> {~dig_nxt[2:0], 2'b00});
  assign byte_nxt     = bytes_q[dig_nxt[3:1]];
  assign data_nib0    = bytes_q[0][7:4];
  assign data_nib_nxt = dig_nxt[0] ? byte_nxt[3:0] : byte_nxt[7:4];

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    drop_d   = drop_q;
    store    = 1'b0;
    latch_id = 1'b0;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (bus.rx_valid) begin
          store = (cnt_q < MAX_CNT);
          if (store) cnt_d = cnt_q + 4'd1;
          if (bus.rx_last) begin
            latch_id = 1'b1;
            state_d  = S_PREFIX;
            tvalid_d = 1'b1;
            tdata_d  = bus.rx_ide ? CH_X : CH_S;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      default: begin
        if (bus.rx_valid && bus.rx_last && (drop_q != 16'hFFFF))
          drop_d = drop_q + 16'd1;
        // Each emit state loads the following character on the handshake.
        if (hs) begin
          case (state_q)
            S_PREFIX: begin
              state_d = S_ID;
              dig_d   = '0;
              tdata_d = hex_char(id_nib0);
            end
            S_ID: begin
              if (dig_q == id_last) begin
                state_d = S_COLON;
                tdata_d = CH_COLON;
              end else begin
                dig_d   = dig_nxt;
                tdata_d = hex_char(id_nib_nxt);
              end
            end
            S_COLON: begin
              if (cnt_q == 4'd0) begin
                state_d = S_CR;
                tdata_d = CH_CR;
              end else begin
                state_d = S_DATA;
                dig_d   = '0;
                tdata_d = hex_char(data_nib0);
              end
            end
            S_DATA: begin
              if ({1'b0, dig_q} == data_last) begin
                state_d = S_CR;
                tdata_d = CH_CR;
`ifdef CAN_HEX_FMT_SPACE_EN
              end else if (dig_q[0]) begin
                state_d = S_SPACE;
                tdata_d = CH_SP;
`endif
              end else begin
                dig_d   = dig_nxt;
                tdata_d = hex_char(data_nib_nxt);
              end
            end
`ifdef CAN_HEX_FMT_SPACE_EN
            S_SPACE: begin
              state_d = S_DATA;
              dig_d   = dig_nxt;
              tdata_d = hex_char(data_nib_nxt);
            end
`endif
            S_CR: begin
              state_d = S_LF;
              tdata_d = CH_LF;
            end
            S_LF: begin
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              cnt_d    = '0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dig_q    <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      drop_q   <= '0;
      id_q     <= '0;
      ide_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      drop_q   <= drop_d;
      if (latch_id) begin
        id_q  <= bus.rx_id;
        ide_q <= bus.rx_ide;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) bytes_q[cnt_q[2:0]] <= bus.rx_data;
  end

  assign bus.o_tvalid = tvalid_q;
  assign bus.o_tdata  = tdata_q;
  assign drop_cnt     = drop_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_COLLECT);
endmodule

// File: tb/tb_can_rx_hex_formatter.sv
// Self-checking bench for can_rx_hex_formatter: vector table, corner sequences,
// and random frames with random back-pressure against a string-level line model.
module tb_can_rx_hex_formatter;
  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] drop_cnt;
  logic        busy;
  logic        stall_en = 1'b0;

  can_rx_hex_formatter_if bus ();

  can_rx_hex_formatter #(.MAX_BYTES(MAXB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: records every accepted character and every stalled-cycle hold.
  logic [7:0] got[$];
  int         got_t[$];
  logic [7:0] hold_e[$];
  logic [7:0] hold_a[$];
  logic       hold_v[$];
  int         cyc = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        hold_e.push_back(prev_data);
        hold_a.push_back(bus.o_tdata);
        hold_v.push_back(bus.o_tvalid);
      end
      if (bus.o_tvalid && bus.o_tready) begin
        got.push_back(bus.o_tdata);
        got_t.push_back(cyc);
      end
      prev_stall = bus.o_tvalid && !bus.o_tready;
      prev_data  = bus.o_tdata;
    end
  end

  initial begin
    bus.o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.o_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic string crlf();
    return $sformatf("%c%c", 8'd13, 8'd10);
  endfunction

  function automatic string show(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'd13)      r = {r, "<CR>"};
      else if (s[i] == 8'd10) r = {r, "<LF>"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  function automatic string hexs(logic [31:0] v, int nd);
    string digs = "0123456789ABCDEF";
    string s = "";
    for (int i = nd - 1; i >= 0; i--) s = $sformatf("%s%c", s, digs[v[4*i +: 4]]);
    return s;
  endfunction

  function automatic string model_line(logic ide, logic [28:0] id, int n, logic [79:0] pk);
    string s;
    int m;
    s = ide ? {"X", hexs({3'b000, id}, 8)} : {"S", hexs({21'd0, id[10:0]}, 3)};
    s = {s, ":"};
    m = (n < MAXB) ? n : MAXB;
    for (int i = 0; i < m; i++) begin
`ifdef CAN_HEX_FMT_SPACE_EN
      if (i > 0) s = {s, " "};
`endif
      s = {s, hexs({24'd0, pk[79-8*i -: 8]}, 2)};
    end
    return {s, crlf()};
  endfunction

  task automatic check(string name, logic ok, string act, string exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  task automatic send_frame(logic ide, logic [28:0] id, int n, logic [79:0] pk);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_last  = (i == n - 1);
      bus.rx_data  = pk[79-8*i -: 8];
      bus.rx_id    = (i == n - 1) ? id : 29'($urandom);
      bus.rx_ide   = (i == n - 1) ? ide : 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
  endtask

  int rd_ptr = 0;

  task automatic wait_line(int len, int budget, output string s, output int span);
    int k = 0;
    int c = 0;
    s = "";
    while ((got.size() - rd_ptr) < len && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    span = ((got.size() - rd_ptr) >= len) ? (got_t[rd_ptr+len-1] - got_t[rd_ptr]) : -1;
    while (rd_ptr < got.size() && c < len) begin
      s = $sformatf("%s%c", s, got[rd_ptr]);
      rd_ptr++;
      c++;
    end
  endtask

  typedef struct {
    logic        ide;
    logic [28:0] id;
    int          n;
    logic [79:0] pk;
    string       exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(logic ide, logic [28:0] id, int n, logic [79:0] pk, string exp);
    vec_t v;
    v.ide = ide; v.id = id; v.n = n; v.pk = pk; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    string line, expl;
    int span;
    int k;
    logic found;

    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_id    = '0;
    bus.rx_ide   = 1'b0;

`ifdef CAN_HEX_FMT_SPACE_EN
    add_vec(1'b0, 29'h123,      4,  {8'h00, 8'h00, 8'h00, 8'h01, 48'h0}, "S123:00 00 00 01");
    add_vec(1'b1, 29'h12345678, 1,  {8'hAB, 72'h0},                      "X12345678:AB");
    add_vec(1'b1, 29'h12345678, 2,  {8'hDE, 8'hAD, 64'h0},               "X12345678:DE AD");
    add_vec(1'b0, 29'h7FF,      1,  {8'hFF, 72'h0},                      "S7FF:FF");
    add_vec(1'b0, 29'h000,      10, 80'h00010203040506070809,            "S000:00 01 02 03 04 05 06 07");
    add_vec(1'b1, 29'h1FFFFFFF, 1,  {8'h3C, 72'h0},                      "X1FFFFFFF:3C");
    add_vec(1'b0, 29'h1ABC,     2,  {8'h5A, 8'hC3, 64'h0},               "S2BC:5A C3");
`else
    add_vec(1'b0, 29'h123,      4,  {8'h00, 8'h00, 8'h00, 8'h01, 48'h0}, "S123:00000001");
    add_vec(1'b1, 29'h12345678, 1,  {8'hAB, 72'h0},                      "X12345678:AB");
    add_vec(1'b1, 29'h12345678, 2,  {8'hDE, 8'hAD, 64'h0},               "X12345678:DEAD");
    add_vec(1'b0, 29'h7FF,      1,  {8'hFF, 72'h0},                      "S7FF:FF");
    add_vec(1'b0, 29'h000,      10, 80'h00010203040506070809,            "S000:0001020304050607");
    add_vec(1'b1, 29'h1FFFFFFF, 1,  {8'h3C, 72'h0},                      "X1FFFFFFF:3C");
    add_vec(1'b0, 29'h1ABC,     2,  {8'h5A, 8'hC3, 64'h0},               "S2BC:5AC3");
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_tvalid", bus.o_tvalid == 1'b0, $sformatf("%0b", bus.o_tvalid), "0");
    check("reset_tdata",  bus.o_tdata == 8'h00, $sformatf("%02h", bus.o_tdata), "00");
    check("reset_drop",   drop_cnt == 16'h0,    $sformatf("%0h", drop_cnt), "0");
    check("reset_busy",   busy == 1'b0,         $sformatf("%0b", busy), "0");

    // Vector table, o_tready held high
    foreach (vecs[i]) begin
      expl = {vecs[i].exp, crlf()};
      send_frame(vecs[i].ide, vecs[i].id, vecs[i].n, vecs[i].pk);
      check($sformatf("vec%0d_first_char", i),
            bus.o_tvalid && bus.o_tdata == (vecs[i].ide ? 8'h58 : 8'h53),
            $sformatf("valid=%0b data=%02h", bus.o_tvalid, bus.o_tdata),
            $sformatf("valid=1 data=%02h", vecs[i].ide ? 8'h58 : 8'h53));
      wait_line(expl.len(), expl.len() + 10, line, span);
      check($sformatf("vec%0d_line", i), line == expl, show(line), show(expl));
      check($sformatf("vec%0d_no_bubbles", i), span == expl.len() - 1,
            $sformatf("%0d", span), $sformatf("%0d", expl.len() - 1));
    end

    // Frame arriving mid-line is dropped whole
    expl = model_line(1'b0, 29'h0AB, 2, {8'h11, 8'h22, 64'h0});
    send_frame(1'b0, 29'h0AB, 2, {8'h11, 8'h22, 64'h0});
    check("busy_emitting", busy == 1'b1, $sformatf("%0b", busy), "1");
    send_frame(1'b0, 29'h155, 3, {8'h01, 8'h02, 8'h03, 56'h0});
    check("drop_cnt_1", drop_cnt == 16'd1, $sformatf("%0d", drop_cnt), "1");
    wait_line(expl.len(), 60, line, span);
    check("drop_first_line", line == expl, show(line), show(expl));
    repeat (20) @(posedge clk);
    #1;
    check("drop_no_extra_line", got.size() == rd_ptr,
          $sformatf("%0d chars", got.size() - rd_ptr), "0 chars");

    // Byte on LF handshake is dropped; byte on the following cycle is accepted
    send_frame(1'b1, 29'h42, 1, {8'h99, 72'h0});
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      @(negedge clk);
      found = bus.o_tvalid && bus.o_tready && bus.o_tdata == 8'h0A;
      k++;
    end
    check("lf_seen", found, $sformatf("%0b", found), "1");
    bus.rx_valid = 1'b1; bus.rx_last = 1'b1; bus.rx_data = 8'h77;
    bus.rx_id = 29'h3; bus.rx_ide = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_data = 8'h5A; bus.rx_id = 29'h001; bus.rx_ide = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0;
    expl = model_line(1'b1, 29'h42, 1, {8'h99, 72'h0});
    wait_line(expl.len(), 60, line, span);
    check("lf_cycle_line", line == expl, show(line), show(expl));
    check("drop_cnt_2", drop_cnt == 16'd2, $sformatf("%0d", drop_cnt), "2");
    expl = "S001:5A";
    expl = {expl, crlf()};
    wait_line(expl.len(), 60, line, span);
    check("after_lf_line", line == expl, show(line), show(expl));

    // Reset in the middle of the ID digits
    send_frame(1'b1, 29'h0ABCDEF1, 1, {8'h42, 72'h0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_tvalid", bus.o_tvalid == 1'b0, $sformatf("%0b", bus.o_tvalid), "0");
    check("midreset_drop",   drop_cnt == 16'd0,    $sformatf("%0d", drop_cnt), "0");
    check("midreset_busy",   busy == 1'b0,         $sformatf("%0b", busy), "0");
    rd_ptr = got.size();
    repeat (20) @(posedge clk);
    #1;
    check("midreset_silent", got.size() == rd_ptr,
          $sformatf("%0d chars", got.size() - rd_ptr), "0 chars");
    expl = model_line(1'b0, 29'h456, 3, {8'h01, 8'h23, 8'h45, 56'h0});
    send_frame(1'b0, 29'h456, 3, {8'h01, 8'h23, 8'h45, 56'h0});
    wait_line(expl.len(), 60, line, span);
    check("postreset_line", line == expl, show(line), show(expl));

    // Random frames under random back-pressure
    stall_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      logic        r_ide;
      logic [28:0] r_id;
      int          r_n;
      logic [79:0] r_pk;
      r_ide = 1'($urandom_range(0, 1));
      r_id  = 29'($urandom);
      r_n   = $urandom_range(1, 10);
      r_pk  = {16'($urandom), $urandom, $urandom};
      expl  = model_line(r_ide, r_id, r_n, r_pk);
      send_frame(r_ide, r_id, r_n, r_pk);
      wait_line(expl.len(), 1000, line, span);
      check($sformatf("rand%0d_line", f), line == expl, show(line), show(expl));
    end
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int h = 0; h < hold_e.size(); h++) begin
      check($sformatf("stall_hold%0d", h), hold_v[h] && hold_a[h] == hold_e[h],
            $sformatf("valid=%0b data=%02h", hold_v[h], hold_a[h]),
            $sformatf("valid=1 data=%02h", hold_e[h]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/can_rx_hex_formatter.md
# can_rx_hex_formatter

Converts frames received by the CAN controller into printable ASCII lines for the UART TX path. The block sits between the CAN controller's byte-wise receive output (`rx_valid`/`rx_last`/`rx_data`/`rx_id`/`rx_ide`) and the UART transmitter's stream input. It buffers one frame, then emits it as uppercase hex text under a valid/ready handshake. Frames arriving while a line is being emitted are dropped and counted.

## Interface
- `MAX_BYTES`, default 8: maximum number of data bytes stored per frame (1..8). Bytes beyond this are discarded.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx_valid`  input  1  one received data byte is present this cycle (no back-pressure).
- `rx_last`  input  1  qualifies `rx_valid`; marks the last byte of a frame.
- `rx_data`  input  8  received data byte.
- `rx_id`  input  29  frame ID; sampled when `rx_valid & rx_last`. Standard IDs occupy `[10:0]`.
- `rx_ide`  input  1  1 = extended frame, 0 = standard frame; sampled with `rx_id`.
- `o_tvalid`  output  1  an ASCII character is available on `o_tdata`.
- `o_tready`  input  1  the downstream stage accepts the character.
- `o_tdata`  output  8  ASCII character.
- `drop_cnt`  output  16  number of frames dropped because the block was busy; saturates at 0xFFFF.
- `busy`  output  1  high in any emit state.

## Operation
- **Line format**
  - Standard frame: `'S'`, 3 hex digits of `id[10:0]`, `':'`, 2 hex digits per data byte, CR (0x0D), LF (0x0A).
  - Extended frame: `'X'`, 8 hex digits of `{3'b000, id[28:0]}`, then the same tail.
  - Hex digits are uppercase (`0-9`, `A-F`). Most-significant nibble first; bytes are sent in arrival order.
- **State machine:** IDLE, COLLECT, PREFIX, ID, COLON, DATA, CR, LF.
  - IDLE or COLLECT with `rx_valid`: store the byte if the count is below `MAX_BYTES` (4-bit count, increments only on store). Then:
    - if `rx_last`, latch ID and IDE and go to PREFIX;
    - otherwise go to (or stay in) COLLECT.
  - PREFIX → ID → COLON → DATA → CR → LF → IDLE. Each state advances only on the `o_tvalid & o_tready` handshake of its last character.
  - Digit counters:
    - ID state: 3 nibbles (standard) or 8 nibbles (extended).
    - DATA state: 2 × count nibbles.
- **Drop rule:** `rx_valid` in any emit state (PREFIX..LF) is ignored, including the cycle of the final LF handshake. When a dropped byte carries `rx_last`, `drop_cnt` increments (saturating). A frame whose first byte is dropped is dropped entirely. Later bytes of that frame arriving after IDLE is reached form a new partial frame, which is emitted normally.
- **Output stability:** `o_tvalid`/`o_tdata` are registered. While `o_tvalid & ~o_tready`, `o_tdata` holds its value.
- **Reset:** mid-line reset aborts the line; no partial CR/LF is emitted after reset.

## Timing
- Reset values:
  - `o_tvalid`=0, `o_tdata`=0x00, `drop_cnt`=0, `busy`=0;
  - state = IDLE, byte count = 0.
- Latency: the first character (`'S'`/`'X'`) appears with `o_tvalid`=1 on the cycle after the `rx_valid & rx_last` cycle.
- Throughput: one character per cycle while `o_tready`=1; no bubbles between characters of a line.
- After the LF handshake, the state is IDLE on the next cycle and `rx_valid` is accepted from that cycle.
- `busy` is high from the cycle after frame commit through the LF handshake cycle.

## Configuration
- `CAN_HEX_FMT_SPACE_EN`
  - Defined: adds a SPACE state in DATA that emits `' '` (0x20) between consecutive data bytes. No space after the last byte, no space after `':'`.
  - Undefined: data hex digits are contiguous and the SPACE state does not exist.

## Test plan
- Standard frame, ID 0x123, bytes 00 00 00 01, `o_tready`=1 → 15 characters `"S123:00000001\r\n"` on consecutive cycles, starting 1 cycle after `rx_last`.
- Extended frame, ID 0x12345678, single byte 0xAB → `"X12345678:AB\r\n"`. With `CAN_HEX_FMT_SPACE_EN` and bytes DE AD → `"X12345678:DE AD\r\n"`.
- `o_tready` toggled randomly during a line → output sequence identical, `o_tdata` stable while stalled, no character lost or duplicated.
- Second frame (3 bytes, last flagged) sent while the first line is emitting → `drop_cnt`=1, only the first line appears. A byte presented on the LF-handshake cycle is also dropped.
- Frame of 10 bytes with `MAX_BYTES`=8 → only the first 8 bytes are printed (16 hex digits).
- `rst` asserted mid-ID digits → next cycle `o_tvalid`=0 and `drop_cnt`=0. A following frame prints a complete, correct line.
